// File: rtl/warp_pc_fetch.sv
// Per-warp PC file with a round-robin fetch scheduler feeding the instruction cache.
// Optional FETCH_CNT_EN adds FetchCnt_PC, a saturating count of granted fetches.
module warp_pc_fetch #(
    parameter int PC_WIDTH  = 32,
    parameter int NUM_WARPS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Update_TM_PC,
    input  logic [2:0]                      WarpID_TM_PC,
    input  logic [PC_WIDTH-1:0]             StartPC_TM_PC,
    input  logic [NUM_WARPS-1:0]            Exit_ID_PC,
    input  logic [NUM_WARPS-1:0]            UpdatePC_Qual1_SIMT_PC,
    input  logic [NUM_WARPS-1:0]            UpdatePC_Qual2_SIMT_PC,
    input  logic [NUM_WARPS*PC_WIDTH-1:0]   TargetAddr_SIMT_PC_Flattened,
    input  logic [NUM_WARPS-1:0]            UpdatePC_Qual3_ID_PC,
    input  logic [PC_WIDTH-1:0]             TargetAddr_ID_PC,
    input  logic [NUM_WARPS-1:0]            Stall_SIMT_PC,
    input  logic [NUM_WARPS-1:0]            Full_IB_PC,
    input  logic                            Stall_ICache_PC,
    output logic                            FetchValid_PC_ICache,
    output logic [PC_WIDTH-1:0]             FetchAddr_PC_ICache,
    output logic [2:0]                      FetchWarpID_PC_ICache,
`ifdef FETCH_CNT_EN
    output logic [15:0]                     FetchCnt_PC,
`endif
    output logic [NUM_WARPS-1:0]            Active_PC
);

    localparam int WID_W = 3;

    logic [NUM_WARPS-1:0]                launch;
    logic [NUM_WARPS-1:0]                redirected;
    logic [NUM_WARPS-1:0]                eligible;
    logic [NUM_WARPS-1:0]                active_all;
    logic [NUM_WARPS-1:0][PC_WIDTH-1:0]  pc_all;

    logic [WID_W-1:0]    last_grant_q, last_grant_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic [PC_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [WID_W-1:0]    fetch_warp_q, fetch_warp_d;

    logic                grant_valid;
    logic                grant_fire;
    logic [WID_W-1:0]    grant_id;
    logic [WID_W-1:0]    scan_idx;

    // Per-warp PC/Active state with the fixed update priority.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [PC_WIDTH-1:0] pc_q, pc_d;
            logic                active_q, active_d;
            logic [PC_WIDTH-1:0] target_simt;

            assign target_simt     = TargetAddr_SIMT_PC_Flattened[gi*PC_WIDTH +: PC_WIDTH];
            assign launch[gi]      = Update_TM_PC && (WarpID_TM_PC == WID_W'(gi));
            assign redirected[gi]  = UpdatePC_Qual1_SIMT_PC[gi] | UpdatePC_Qual2_SIMT_PC[gi]
                                   | UpdatePC_Qual3_ID_PC[gi] | launch[gi];
            assign eligible[gi]    = active_q & ~Stall_SIMT_PC[gi] & ~Full_IB_PC[gi]
                                   & ~redirected[gi] & ~Exit_ID_PC[gi];
            assign pc_all[gi]      = pc_q;
            assign active_all[gi]  = active_q;

            always_comb begin
                pc_d     = pc_q;
                active_d = active_q;
                if (launch[gi]) begin
                    pc_d     = StartPC_TM_PC;
                    active_d = 1'b1;
                end else if (Exit_ID_PC[gi]) begin
                    active_d = 1'b0;
                end else if (UpdatePC_Qual1_SIMT_PC[gi] || UpdatePC_Qual2_SIMT_PC[gi]) begin
                    pc_d = target_simt;
                end else if (UpdatePC_Qual3_ID_PC[gi]) begin
                    pc_d = TargetAddr_ID_PC;
                end else if (grant_fire && (grant_id == WID_W'(gi))) begin
                    pc_d = pc_q + PC_WIDTH'(4);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pc_q     <= '0;
                    active_q <= 1'b0;
                end else begin
                    pc_q     <= pc_d;
                    active_q <= active_d;
                end
            end
        end
    endgenerate

    // Scan from the farthest offset down so the nearest eligible warp after LastGrant wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = last_grant_q;
        scan_idx    = '0;
        for (int off = NUM_WARPS; off >= 1; off--) begin
            scan_idx = last_grant_q + WID_W'(off);
            if (eligible[scan_idx]) begin
                grant_valid = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    assign grant_fire = grant_valid & ~Stall_ICache_PC;

    always_comb begin
        last_grant_d  = last_grant_q;
        fetch_valid_d = fetch_valid_q;
        fetch_addr_d  = fetch_addr_q;
        fetch_warp_d  = fetch_warp_q;
        if (!Stall_ICache_PC) begin
            fetch_valid_d = grant_valid;
            if (grant_valid) begin
                fetch_addr_d = pc_all[grant_id];
                fetch_warp_d = grant_id;
                last_grant_d = grant_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q  <= WID_W'(NUM_WARPS - 1);
            fetch_valid_q <= 1'b0;
            fetch_addr_q  <= '0;
            fetch_warp_q  <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_addr_q  <= fetch_addr_d;
            fetch_warp_q  <= fetch_warp_d;
        end
    end

`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (grant_fire && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign FetchCnt_PC = fetch_cnt_q;
`endif

    assign FetchValid_PC_ICache  = fetch_valid_q;
    assign FetchAddr_PC_ICache   = fetch_addr_q;
    assign FetchWarpID_PC_ICache = fetch_warp_q;
    assign Active_PC             = active_all;

    // Decode guarantees at most one Qual3 redirect per cycle (shared target bus).
    qual3_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(UpdatePC_Qual3_ID_PC));

endmodule

// File: doc/warp_pc_fetch.md
# warp_pc_fetch

Per-warp program-counter file and round-robin fetch scheduler for the 8-warp SIMT core. It sits directly upstream of the SIMT stack and the instruction buffer. It holds one PC per warp and applies warp launches from the Task Manager and redirects from the SIMT stack and decode. Each cycle it issues at most one registered fetch request (address plus warp ID) to the instruction cache.

## Interface
- PC_WIDTH, 32, PC width in bits; all PCs are byte addresses and word-aligned.
- NUM_WARPS, 8, warp count; fixed by the 8-bit per-warp vectors below.

- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Update_TM_PC  input  1  launch warp WarpID_TM_PC at StartPC_TM_PC.
- WarpID_TM_PC  input  3  warp being launched.
- StartPC_TM_PC  input  32  initial PC for the launch.
- Exit_ID_PC  input  8  per-warp exit; clears Active.
- UpdatePC_Qual1_SIMT_PC  input  8  per-warp redirect, priority 1 (ALU-resolved branch).
- UpdatePC_Qual2_SIMT_PC  input  8  per-warp redirect, priority 2 (decode-resolved call/ret/jmp/reconvergence).
- TargetAddr_SIMT_PC_Flattened  input  256  target for warp w in bits [32w+31:32w]; used by Qual1 and Qual2.
- UpdatePC_Qual3_ID_PC  input  8  per-warp redirect from decode, priority 3.
- TargetAddr_ID_PC  input  32  target for Qual3; shared, at most one Qual3 bit is set.
- Stall_SIMT_PC  input  8  per-warp fetch stall.
- Full_IB_PC  input  8  per-warp instruction buffer full.
- Stall_ICache_PC  input  1  cache busy; the current request is held.
- FetchValid_PC_ICache  output  1  fetch request valid.
- FetchAddr_PC_ICache  output  32  fetch address.
- FetchWarpID_PC_ICache  output  3  warp ID of the fetch.
- Active_PC  output  8  per-warp active flags.

## Operation
- **State per warp w:**
  - PC[w] (32 bits) and Active[w].
  - Round-robin pointer LastGrant (3 bits): the warp most recently granted.
- **PC update priority per warp at each clock edge, highest first:**
  1. TM launch (WarpID_TM_PC==w): PC←StartPC_TM_PC, Active←1.
  2. Exit: Active←0, PC unchanged.
  3. Qual1: PC←TargetAddr slice w.
  4. Qual2: PC←TargetAddr slice w.
  5. Qual3: PC←TargetAddr_ID_PC.
  6. Fetch grant to w: PC←PC+4.
  7. Otherwise: hold.
- **Redirected(w)** = Qual1[w] | Qual2[w] | Qual3[w] | launch of w.
- **Eligible(w)** = Active[w] & ~Stall_SIMT_PC[w] & ~Full_IB_PC[w] & ~Redirected(w) & ~Exit_ID_PC[w].
- **Grant:** issued when Stall_ICache_PC==0 and any warp is eligible. The grant goes to the first eligible warp scanning LastGrant+1, LastGrant+2, … with mod-8 wrap.
- **On grant:**
  - FetchValid←1, FetchAddr←PC[g], FetchWarpID←g.
  - PC[g]←PC[g]+4 (modulo 2^32, carry discarded).
  - LastGrant←g.
- **No grant, Stall_ICache_PC==0:** FetchValid←0; address and warp ID hold.
- **Stall_ICache_PC==1:**
  - All fetch outputs hold.
  - No PC increments and LastGrant holds.
  - Redirects, launches and exits still apply.
- **In-flight fetches:** a request already issued for a warp that is later redirected is not recalled. The SIMT stack drops it at the instruction buffer via DropInstr.
- **Two Qual3 bits set at once** is illegal; the block asserts only in simulation.

## Timing
- **Reset values:**
  - PC[*]=0, Active=0, LastGrant=7 (so warp 0 is scanned first).
  - FetchValid=0, FetchAddr=0, FetchWarpID=0.
- **Grant latency:** one cycle. Inputs sampled in cycle t produce the request registered at edge t+1.
- **After a redirect** in cycle t, warp w is first eligible in t+1 and its fetch uses the new PC.
- **After a launch** in cycle t, the warp is first eligible in t+1.
- **Stall_SIMT_PC and Full_IB_PC** act combinationally on the same-cycle grant.
- **Reset asserted mid-operation:** all state clears immediately (asynchronous reset). FetchValid drops without waiting for the clock.

## Configuration
- **FETCH_CNT_EN defined:**
  - Adds output FetchCnt_PC  output  16, a saturating count of granted fetches.
  - Reset to 0; increments on each grant; holds at 16'hFFFF.
- **FETCH_CNT_EN undefined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Reset and launch:** launch warp 3 at 0x100. Next cycle the request is FetchValid=1, Addr=0x100, WarpID=3. The cycle after gives Addr=0x104.
- **Round robin:** launch warps 0, 2, 5 at 0x0, 0x40, 0x80 with no stalls. Fetch order is 0, 2, 5, 0 with addresses 0x0, 0x40, 0x80, 0x4.
- **Priority:** in one cycle on warp 1, assert Qual1 (target 0x200), Qual2 (0x200 slice) and Qual3 (0x300). PC becomes 0x200. Warp 1 is not granted that cycle, and its next fetch uses 0x200.
- **Stalls:**
  - Full_IB_PC[2]=1 skips warp 2 until it deasserts.
  - Stall_ICache_PC=1 for 3 cycles holds the Addr and WarpID outputs with no PC increment.
- **Exit and wrap:** launch warp 7 at 0xFFFFFFFC. Its fetch yields 0xFFFFFFFC, then PC wraps to 0x0. Exit_ID_PC[7] clears Active and no further warp 7 fetches occur.
- **FETCH_CNT_EN:** after 70000 grants, FetchCnt_PC=0xFFFF. A mid-run asynchronous reset returns it to 0 and FetchValid to 0.
